// File: rtl/ram_write_ctrl.sv
// Front end for the 8x8 display RAM pair: conditions raw keys and switches into
// single-cycle writes, a zero-fill sweep on clear, and a manual or auto-scanned read address.
module ram_write_ctrl #(
    parameter int unsigned ADDR_W    = 3,
    parameter int unsigned DATA_W    = 8,
    parameter logic [19:0] DB_CYCLES = 20'd1_000_000,
    parameter logic [25:0] SCAN_DIV  = 26'd50_000_000
) (
    input  logic              clk,
    input  logic              clrn,
    input  logic              key_wr,
    input  logic              key_clr,
    input  logic [ADDR_W-1:0] sw_waddr,
    input  logic [DATA_W-1:0] sw_data,
    input  logic [ADDR_W-1:0] sw_raddr,
    input  logic              scan_mode,
    output logic              we,
    output logic [ADDR_W-1:0] inaddr,
    output logic [DATA_W-1:0] din,
    output logic [ADDR_W-1:0] outaddr,
    output logic              busy
);

    localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

    typedef enum logic [1:0] {StIdle, StWrite, StClear} state_e;

    // Key index 0 is the write key, index 1 the clear key.
    logic [1:0]  sync1_q, sync2_q, db_q, db_d, db_dly_q;
    logic [19:0] db_cnt_q [2];
    logic [19:0] db_cnt_d [2];
    logic        wr_req, clr_req;

    logic [ADDR_W-1:0] sw_waddr_q, sw_raddr_q;
    logic [DATA_W-1:0] sw_data_q;
    logic              scan_mode_q;

    state_e            state_q, state_d;
    logic              we_q, we_d, busy_q, busy_d;
    logic [ADDR_W-1:0] inaddr_q, inaddr_d;
    logic [DATA_W-1:0] din_q, din_d;

    logic [25:0]       div_q, div_d;
    logic [ADDR_W-1:0] outaddr_q, outaddr_d;

    // Level flips only once DB_CYCLES consecutive samples disagree with it.
    always_comb begin
        for (int k = 0; k < 2; k++) begin
            db_d[k]     = db_q[k];
            db_cnt_d[k] = '0;
            if (sync2_q[k] != db_q[k]) begin
                if (db_cnt_q[k] == DB_CYCLES - 20'd1) begin
                    db_d[k] = ~db_q[k];
                end else begin
                    db_cnt_d[k] = db_cnt_q[k] + 20'd1;
                end
            end
        end
    end

    assign wr_req  = db_q[0] & ~db_dly_q[0];
    assign clr_req = db_q[1] & ~db_dly_q[1];

    always_comb begin
        state_d  = state_q;
        we_d     = 1'b0;
        busy_d   = 1'b0;
        inaddr_d = inaddr_q;
        din_d    = din_q;
        unique case (state_q)
            StIdle: begin
                if (clr_req) begin
                    state_d  = StClear;
                    inaddr_d = '0;
                    din_d    = '0;
                    we_d     = 1'b1;
                    busy_d   = 1'b1;
                end else if (wr_req) begin
                    state_d  = StWrite;
                    inaddr_d = sw_waddr_q;
                    din_d    = sw_data_q;
                    we_d     = 1'b1;
                    busy_d   = 1'b1;
                end
            end
            StWrite: state_d = StIdle;
            StClear: begin
                if (inaddr_q == ADDR_MAX) begin
                    state_d = StIdle;
                end else begin
                    inaddr_d = inaddr_q + ADDR_ONE;
                    we_d     = 1'b1;
                    busy_d   = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Divider stays cleared in manual mode so a scan always starts with a full step.
    always_comb begin
        div_d     = '0;
        outaddr_d = outaddr_q;
        if (!scan_mode_q) begin
            outaddr_d = sw_raddr_q;
        end else if (div_q == SCAN_DIV - 26'd1) begin
            outaddr_d = outaddr_q + ADDR_ONE;
        end else begin
            div_d = div_q + 26'd1;
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            db_q        <= '0;
            db_dly_q    <= '0;
            for (int k = 0; k < 2; k++) begin
                db_cnt_q[k] <= '0;
            end
            sw_waddr_q  <= '0;
            sw_raddr_q  <= '0;
            sw_data_q   <= '0;
            scan_mode_q <= 1'b0;
            state_q     <= StIdle;
            we_q        <= 1'b0;
            busy_q      <= 1'b0;
            inaddr_q    <= '0;
            din_q       <= '0;
            div_q       <= '0;
            outaddr_q   <= '0;
        end else begin
            sync1_q     <= {key_clr, key_wr};
            sync2_q     <= sync1_q;
            db_q        <= db_d;
            db_dly_q    <= db_q;
            for (int k = 0; k < 2; k++) begin
                db_cnt_q[k] <= db_cnt_d[k];
            end
            sw_waddr_q  <= sw_waddr;
            sw_raddr_q  <= sw_raddr;
            sw_data_q   <= sw_data;
            scan_mode_q <= scan_mode;
            state_q     <= state_d;
            we_q        <= we_d;
            busy_q      <= busy_d;
            inaddr_q    <= inaddr_d;
            din_q       <= din_d;
            div_q       <= div_d;
            outaddr_q   <= outaddr_d;
        end
    end

    assign we      = we_q;
    assign busy    = busy_q;
    assign inaddr  = inaddr_q;
    assign din     = din_q;
    assign outaddr = outaddr_q;

endmodule

// File: doc/ram_write_ctrl.md
Name: ram_write_ctrl

Overview:
- Upstream stage for the 8x8 display RAM pair in the memory experiment top.
- Turns raw board inputs (address/data switches, write key, clear key, mode switch) into clean RAM control signals: we, inaddr, din, outaddr.
- Debounces the keys and issues exactly one write per key press.
- Sweeps the RAM to zero on a clear request.
- Drives the read address either from switches or from a free-running scan counter.

Parameters:
- ADDR_W, 3, RAM address width; depth is 2^ADDR_W.
- DATA_W, 8, RAM data width.
- DB_CYCLES, 20'd1_000_000, number of consecutive stable samples a key needs to be accepted (20 ms at 50 MHz).
- SCAN_DIV, 26'd50_000_000, clocks per auto-scan address step (1 s at 50 MHz).

Ports:
- clk  input  1  system clock, rising edge.
- clrn  input  1  asynchronous active-low reset.
- key_wr  input  1  raw write key, active-high after board inversion, asynchronous to clk.
- key_clr  input  1  raw clear key, active-high, asynchronous to clk.
- sw_waddr  input  ADDR_W  write address switches.
- sw_data  input  DATA_W  write data switches.
- sw_raddr  input  ADDR_W  manual read address switches.
- scan_mode  input  1  0 = manual read address, 1 = auto-scan.
- we  output  1  RAM write enable.
- inaddr  output  ADDR_W  RAM write address.
- din  output  DATA_W  RAM write data.
- outaddr  output  ADDR_W  RAM read address.
- busy  output  1  high while a write or clear is in progress.

Behaviour:
- Reset (clrn=0, asynchronous): we=0, inaddr=0, din=0, outaddr=0, busy=0, FSM=IDLE, all counters and synchronizers cleared. Reset mid-clear abandons the sweep immediately; no further we pulses occur.
- Input conditioning:
  - Each key passes through a 2-flop synchronizer, then a debounce counter.
  - The debounced level changes only after DB_CYCLES consecutive identical synchronized samples; any toggle restarts the count.
  - A rising edge of the debounced level produces a one-cycle request pulse (wr_req / clr_req).
  - Switch inputs (sw_*, scan_mode) are registered once before use.
- FSM states: IDLE, WRITE, CLEAR.
  - IDLE:
    - If clr_req -> CLEAR: inaddr=0, din=0, we=1, busy=1.
    - Else if wr_req -> WRITE: inaddr=sw_waddr, din=sw_data (registered values), we=1, busy=1.
    - clr_req wins when both pulse in the same cycle; that wr_req is dropped.
  - WRITE: lasts exactly one cycle with we=1, then -> IDLE with we=0, busy=0. Write latency: we rises 1 clk after the wr_req pulse.
  - CLEAR:
    - we=1 for 2^ADDR_W consecutive cycles; inaddr increments 0,1,...,7; din=0 throughout.
    - After the cycle with inaddr = 2^ADDR_W-1 -> IDLE: we=0, busy=0, inaddr holds the last value.
    - wr_req or clr_req arriving during WRITE/CLEAR is ignored, not queued.
- we is registered and never high in IDLE.
- Between operations inaddr/din hold their last values.
- Read address:
  - scan_mode=0: outaddr = registered sw_raddr, one clk latency after the switch register.
  - scan_mode=1: a divider counts 0..SCAN_DIV-1; on the terminal count outaddr increments and wraps from 2^ADDR_W-1 to 0.
  - Switching scan_mode 0->1 starts scanning from the current outaddr with the divider cleared.
  - Switching scan_mode 1->0 loads sw_raddr on the next cycle.
  - Read addressing runs independently of the write FSM, including during CLEAR.

Test Plan (bench overrides DB_CYCLES=3, SCAN_DIV=4):
- Reset: hold clrn=0 for 3 clks with keys pressed -> all outputs 0; release -> no we pulse until a full debounce completes.
- Write: sw_waddr=5, sw_data=8'hA3, key_wr held 10 clks -> exactly one we pulse (1 clk) with inaddr=5, din=8'hA3, busy high for that cycle only.
- Bounce: key_wr toggling every 2 clks for 12 clks, then stable high -> exactly one we pulse, after stability; no pulse during toggling.
- Clear: press key_clr -> 8 consecutive we cycles, inaddr 0..7, din=0, busy=1 for 8 clks; key_wr pressed mid-sweep -> no additional write afterwards.
- Scan: scan_mode=1 from outaddr=6 -> outaddr 6,7,0,1, each held 4 clks; set scan_mode=0 with sw_raddr=2 -> outaddr=2 within 2 clks.
- Reset mid-clear: assert clrn=0 when inaddr=3 -> we=0, inaddr=0 immediately (asynchronously); after release, FSM in IDLE and no we pulses.
